// File: rtl/minisrc_datapath.sv
// Mini SRC phase-1 datapath: shared 32-bit bus, R1/R3/R5, PC, IR, MAR, MDR, Y, 64-bit Z, combinational ALU.
// Define MULDIV_EN to add signed multiply/divide (opcodes 01111/10000); otherwise those opcodes give Z = 0.
module minisrc_datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        R1_in,
    input  logic        R3_in,
    input  logic        R5_in,
    input  logic        PC_in,
    input  logic        IR_in,
    input  logic        MAR_in,
    input  logic        Y_in,
    input  logic        Z_in,
    input  logic        MDR_in,
    input  logic        Read,
    input  logic        R3_out,
    input  logic        R5_out,
    input  logic        PC_out,
    input  logic        MDR_out,
    input  logic        Zlow_out,
    input  logic [4:0]  alu_instruction,
    input  logic [31:0] Mdatain,
    output logic [31:0] Bus_Data,
    output logic [31:0] R1_Data,
    output logic [31:0] R3_Data,
    output logic [31:0] R5_Data,
    output logic [31:0] PC_Data,
    output logic [31:0] IR_Data,
    output logic [31:0] MAR_Data,
    output logic [31:0] MDR_Data,
    output logic [31:0] Y_Data,
    output logic [31:0] Zhigh_Data,
    output logic [31:0] Zlow_Data
);

    localparam logic [4:0] OP_INCPC = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_AND   = 5'b00101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_SHR   = 5'b00111;
    localparam logic [4:0] OP_SHRA  = 5'b01000;
    localparam logic [4:0] OP_SHL   = 5'b01001;
    localparam logic [4:0] OP_ROR   = 5'b01010;
    localparam logic [4:0] OP_ROL   = 5'b01011;
    localparam logic [4:0] OP_NEG   = 5'b10001;
    localparam logic [4:0] OP_NOT   = 5'b10010;
`ifdef MULDIV_EN
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
`endif

    logic [31:0] r_r1, r_r3, r_r5, r_pc, r_ir, r_mar, r_mdr, r_y;
    logic [63:0] r_z;

    logic [31:0] w_bus;
    logic [31:0] w_mdr_next;
    logic [63:0] w_alu;
    logic [4:0]  w_sh;
    logic [5:0]  w_sh_inv;
    logic [31:0] w_ror, w_rol;

    always_comb begin
        if (MDR_out)       w_bus = r_mdr;
        else if (Zlow_out) w_bus = r_z[31:0];
        else if (PC_out)   w_bus = r_pc;
        else if (R5_out)   w_bus = r_r5;
        else if (R3_out)   w_bus = r_r3;
        else               w_bus = 32'h0;
    end

    assign w_mdr_next = Read ? Mdatain : w_bus;

    // A shift of 32 on the wrap-around half yields 0, so a rotate by 0 returns A unchanged.
    assign w_sh     = w_bus[4:0];
    assign w_sh_inv = 6'd32 - {1'b0, w_sh};
    assign w_ror    = (r_y >> w_sh) | (r_y << w_sh_inv);
    assign w_rol    = (r_y << w_sh) | (r_y >> w_sh_inv);

`ifdef MULDIV_EN
    logic signed [63:0] w_prod;
    logic signed [31:0] w_div_b, w_quo, w_rem;
    assign w_prod  = $signed({{32{r_y[31]}}, r_y}) * $signed({{32{w_bus[31]}}, w_bus});
    // Substitute a harmless divisor for zero; the zero case is forced to Z = 0 below.
    assign w_div_b = (w_bus == 32'h0) ? 32'sd1 : $signed(w_bus);
    assign w_quo   = $signed(r_y) / w_div_b;
    assign w_rem   = $signed(r_y) % w_div_b;
`endif

    always_comb begin
        w_alu = 64'h0;
        case (alu_instruction)
            OP_INCPC: w_alu = {32'h0, w_bus + 32'd1};
            OP_ADD:   w_alu = {32'h0, r_y + w_bus};
            OP_SUB:   w_alu = {32'h0, r_y - w_bus};
            OP_AND:   w_alu = {32'h0, r_y & w_bus};
            OP_OR:    w_alu = {32'h0, r_y | w_bus};
            OP_SHR:   w_alu = {32'h0, r_y >> w_sh};
            OP_SHRA:  w_alu = {32'h0, $unsigned($signed(r_y) >>> w_sh)};
            OP_SHL:   w_alu = {32'h0, r_y << w_sh};
            OP_ROR:   w_alu = {32'h0, w_ror};
            OP_ROL:   w_alu = {32'h0, w_rol};
            OP_NEG:   w_alu = {32'h0, 32'h0 - w_bus};
            OP_NOT:   w_alu = {32'h0, ~w_bus};
`ifdef MULDIV_EN
            OP_MUL:   w_alu = $unsigned(w_prod);
            OP_DIV:   w_alu = (w_bus == 32'h0) ? 64'h0 : {$unsigned(w_rem), $unsigned(w_quo)};
`endif
            default:  w_alu = 64'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_r1  <= 32'h0;
            r_r3  <= 32'h0;
            r_r5  <= 32'h0;
            r_pc  <= 32'h0;
            r_ir  <= 32'h0;
            r_mar <= 32'h0;
            r_mdr <= 32'h0;
            r_y   <= 32'h0;
            r_z   <= 64'h0;
        end else begin
            if (R1_in)  r_r1  <= w_bus;
            if (R3_in)  r_r3  <= w_bus;
            if (R5_in)  r_r5  <= w_bus;
            if (PC_in)  r_pc  <= w_bus;
            if (IR_in)  r_ir  <= w_bus;
            if (MAR_in) r_mar <= w_bus;
            if (MDR_in) r_mdr <= w_mdr_next;
            if (Y_in)   r_y   <= w_bus;
            if (Z_in)   r_z   <= w_alu;
        end
    end

    assign Bus_Data   = w_bus;
    assign R1_Data    = r_r1;
    assign R3_Data    = r_r3;
    assign R5_Data    = r_r5;
    assign PC_Data    = r_pc;
    assign IR_Data    = r_ir;
    assign MAR_Data   = r_mar;
    assign MDR_Data   = r_mdr;
    assign Y_Data     = r_y;
    assign Zhigh_Data = r_z[63:32];
    assign Zlow_Data  = r_z[31:0];

endmodule

// File: tb/tb_minisrc_datapath.sv
// Bench for minisrc_datapath: directed datapath sequences plus randomized ALU ops against a reference model.
// Honours MULDIV_EN the same way as the design.
module tb_minisrc_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic        R1_in, R3_in, R5_in, PC_in, IR_in, MAR_in, Y_in, Z_in, MDR_in, Read;
    logic        R3_out, R5_out, PC_out, MDR_out, Zlow_out;
    logic [4:0]  alu_instruction;
    logic [31:0] Mdatain;
    logic [31:0] Bus_Data, R1_Data, R3_Data, R5_Data, PC_Data, IR_Data;
    logic [31:0] MAR_Data, MDR_Data, Y_Data, Zhigh_Data, Zlow_Data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    minisrc_datapath dut (
        .clk(clk), .clr(clr),
        .R1_in(R1_in), .R3_in(R3_in), .R5_in(R5_in), .PC_in(PC_in), .IR_in(IR_in),
        .MAR_in(MAR_in), .Y_in(Y_in), .Z_in(Z_in), .MDR_in(MDR_in), .Read(Read),
        .R3_out(R3_out), .R5_out(R5_out), .PC_out(PC_out), .MDR_out(MDR_out), .Zlow_out(Zlow_out),
        .alu_instruction(alu_instruction), .Mdatain(Mdatain),
        .Bus_Data(Bus_Data), .R1_Data(R1_Data), .R3_Data(R3_Data), .R5_Data(R5_Data),
        .PC_Data(PC_Data), .IR_Data(IR_Data), .MAR_Data(MAR_Data), .MDR_Data(MDR_Data),
        .Y_Data(Y_Data), .Zhigh_Data(Zhigh_Data), .Zlow_Data(Zlow_Data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the opcode table with plain arithmetic.
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        int sa, sb;
        longint p;
        sh = int'(b[4:0]);
        sa = int'(a);
        sb = int'(b);
        r  = a;
        case (op)
            5'd0:  return {32'h0, b + 32'd1};
            5'd3:  return {32'h0, a + b};
            5'd4:  return {32'h0, a - b};
            5'd5:  return {32'h0, a & b};
            5'd6:  return {32'h0, a | b};
            5'd7:  return {32'h0, a >> sh};
            5'd8:  return {32'h0, a[31] ? ~((~a) >> sh) : (a >> sh)};
            5'd9:  return {32'h0, a << sh};
            5'd10: begin
                for (int i = 0; i < sh; i++) r = {r[0], r[31:1]};
                return {32'h0, r};
            end
            5'd11: begin
                for (int i = 0; i < sh; i++) r = {r[30:0], r[31]};
                return {32'h0, r};
            end
            5'd17: return {32'h0, 32'd0 - b};
            5'd18: return {32'h0, ~b};
`ifdef MULDIV_EN
            5'd15: begin
                p = longint'(sa) * longint'(sb);
                return 64'(p);
            end
            5'd16: begin
                if (b == 32'h0) return 64'h0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
`endif
            default: return 64'h0;
        endcase
    endfunction

    task automatic idle();
        R1_in = 0; R3_in = 0; R5_in = 0; PC_in = 0; IR_in = 0; MAR_in = 0;
        Y_in = 0; Z_in = 0; MDR_in = 0; Read = 0;
        R3_out = 0; R5_out = 0; PC_out = 0; MDR_out = 0; Zlow_out = 0;
        alu_instruction = 5'd0; Mdatain = 32'h0; clr = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        idle(); Read = 1; MDR_in = 1; Mdatain = v; tick(); idle();
    endtask

    task automatic load_y(input logic [31:0] v);
        mem_to_mdr(v); MDR_out = 1; Y_in = 1; tick(); idle();
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] b);
        mem_to_mdr(b); MDR_out = 1; Z_in = 1; alu_instruction = op; tick(); idle();
    endtask

    logic [4:0]  ops [14] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                              5'd9, 5'd10, 5'd11, 5'd17, 5'd18, 5'd15, 5'd16};
    logic [31:0] ir_val;
    logic [63:0] exp_z;

    initial begin
        idle();
        clr = 0; tick(); tick(); idle();

        // Simultaneous loads all take the bus value; Z takes x+x.
        mem_to_mdr(32'h1234_5678);
        MDR_out = 1; R1_in = 1; R3_in = 1; R5_in = 1; PC_in = 1; IR_in = 1;
        MAR_in = 1; Y_in = 1; alu_instruction = 5'd3; tick(); idle();
        MDR_out = 1; Z_in = 1; alu_instruction = 5'd3; tick(); idle();
        check("multi_load_r5", R5_Data, 32'h1234_5678);
        check("multi_load_mar", MAR_Data, 32'h1234_5678);
        check("z_add_pre_reset", Zlow_Data, 32'h2468_ACF0);

        // Reset beats a pending load.
        clr = 0; MDR_out = 1; R1_in = 1; Z_in = 1; tick(); idle();
        check("rst_r1", R1_Data, 32'h0);  check("rst_r3", R3_Data, 32'h0);
        check("rst_r5", R5_Data, 32'h0);  check("rst_pc", PC_Data, 32'h0);
        check("rst_ir", IR_Data, 32'h0);  check("rst_mar", MAR_Data, 32'h0);
        check("rst_mdr", MDR_Data, 32'h0); check("rst_y", Y_Data, 32'h0);
        check("rst_zhi", Zhigh_Data, 32'h0); check("rst_zlo", Zlow_Data, 32'h0);
        check("rst_bus", Bus_Data, 32'h0);
        $display("[TB] reset sequence done");

        // PC fetch.
        PC_out = 1; MAR_in = 1; Z_in = 1; alu_instruction = 5'd0; tick(); idle();
        check("fetch_mar", MAR_Data, 32'h0);
        check("fetch_zlo", Zlow_Data, 32'h1);
        Zlow_out = 1; PC_in = 1; tick(); idle();
        check("fetch_pc", PC_Data, 32'h1);
        $display("[TB] pc increment pc=%08h", PC_Data);

        // Instruction fetch, then shr R1, R3, R5.
        ir_val = 32'h389A_8000;
        mem_to_mdr(ir_val); MDR_out = 1; IR_in = 1; tick(); idle();
        check("ir_load", IR_Data, 32'h389A_8000);
        mem_to_mdr(32'h8000_FA92); MDR_out = 1; R3_in = 1; tick(); idle();
        R3_out = 1; Y_in = 1; tick(); idle();
        check("y_from_r3", Y_Data, 32'h8000_FA92);
        mem_to_mdr(32'h0000_000A); MDR_out = 1; R5_in = 1; tick(); idle();
        R5_out = 1; Z_in = 1; alu_instruction = ir_val[31:27]; tick(); idle();
        check("shr_zlo", Zlow_Data, 32'h0020_003E);
        check("shr_zhi", Zhigh_Data, 32'h0);
        Zlow_out = 1; R1_in = 1; tick(); idle();
        check("shr_r1", R1_Data, 32'h0020_003E);
        $display("[TB] shr r1=%08h", R1_Data);

        // Load via MDR, empty bus, and bus priority.
        mem_to_mdr(32'h0000_0595); MDR_out = 1; R1_in = 1; tick(); idle();
        check("ld_r1", R1_Data, 32'h0000_0595);
        #1 check("bus_idle", Bus_Data, 32'h0);
        MDR_out = 1; Zlow_out = 1; PC_out = 1; R5_out = 1; R3_out = 1;
        #1 check("prio_mdr", Bus_Data, 32'h0000_0595);
        MDR_out = 0; #1 check("prio_zlow", Bus_Data, 32'h0020_003E);
        Zlow_out = 0; #1 check("prio_pc", Bus_Data, 32'h1);
        PC_out = 0; #1 check("prio_r5", Bus_Data, 32'hA);
        R5_out = 0; #1 check("prio_r3", Bus_Data, 32'h8000_FA92);
        idle();
        $display("[TB] bus priority done");

        // ALU sweep with Y=0x8000FA92, B=R5=0xA.
        R5_out = 1; Z_in = 1; alu_instruction = 5'b01000; tick(); idle();
        check("sweep_shra", Zlow_Data, 32'hFFE0_003E);
        R5_out = 1; Z_in = 1; alu_instruction = 5'b01010; tick(); idle();
        check("sweep_ror", Zlow_Data, 32'hA4A0_003E);
        R5_out = 1; Z_in = 1; alu_instruction = 5'b00011; tick(); idle();
        check("sweep_add", Zlow_Data, 32'h8000_FA9C);
        R5_out = 1; Z_in = 1; alu_instruction = 5'b10010; tick(); idle();
        check("sweep_not", Zlow_Data, 32'hFFFF_FFF5);
        check("sweep_not_hi", Zhigh_Data, 32'h0);
        R5_out = 1; Z_in = 1; alu_instruction = 5'b11111; tick(); idle();
        check("bad_op_lo", Zlow_Data, 32'h0);
        $display("[TB] alu sweep done");

        // MDR loads from the bus when Read=0.
        R5_out = 1; Z_in = 1; alu_instruction = 5'b10010; tick(); idle();
        Zlow_out = 1; MDR_in = 1; Read = 0; Mdatain = 32'hDEAD_BEEF; tick(); idle();
        check("mdr_from_bus", MDR_Data, 32'hFFFF_FFF5);

        // Multiply/divide directed cases.
        load_y(32'hFFFF_FFFE);
        alu_op(5'b01111, 32'd3);
`ifdef MULDIV_EN
        check("mul_hi", Zhigh_Data, 32'hFFFF_FFFF); check("mul_lo", Zlow_Data, 32'hFFFF_FFFA);
`else
        check("mul_hi", Zhigh_Data, 32'h0); check("mul_lo", Zlow_Data, 32'h0);
`endif
        load_y(32'hFFFF_FFF9);
        alu_op(5'b10000, 32'd2);
`ifdef MULDIV_EN
        check("div_lo", Zlow_Data, 32'hFFFF_FFFD); check("div_hi", Zhigh_Data, 32'hFFFF_FFFF);
`else
        check("div_lo", Zlow_Data, 32'h0); check("div_hi", Zhigh_Data, 32'h0);
`endif
        alu_op(5'b10000, 32'd0);
        check("div0_lo", Zlow_Data, 32'h0); check("div0_hi", Zhigh_Data, 32'h0);
        $display("[TB] mul/div directed done");

        // Randomized ALU ops against the reference model.
        for (int it = 0; it < 60; it++) begin
            logic [31:0] a, b;
            logic [4:0]  op;
            int idx;
            idx = int'($urandom_range(0, 14));
            op  = (idx == 14) ? 5'($urandom_range(0, 31)) : ops[idx];
            a   = $urandom;
            b   = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            exp_z = ref_alu(op, a, b);
            load_y(a);
            alu_op(op, b);
            check("rnd_y", Y_Data, a);
            check("rnd_zlo", Zlow_Data, exp_z[31:0]);
            check("rnd_zhi", Zhigh_Data, exp_z[63:32]);
            $display("[TB] rnd %0d op=%05b a=%08h b=%08h z=%08h_%08h", it, op, a, b, Zhigh_Data, Zlow_Data);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
